// File: rtl/servo_cmd_framer.sv
// rtl/servo_cmd_framer.sv - servo command to ASCII "#IDPpwmTtime!" frame serializer
module servo_cmd_framer #(
    parameter int NUM_SERVO   = 6,
    parameter int ID_DIGITS   = 3,
    parameter int PWM_DIGITS  = 4,
    parameter int TIME_DIGITS = 4,
    parameter int PWM_MIN     = 500,
    parameter int PWM_MAX     = 2500,
    parameter int APPEND_CRLF = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_id,
    input  logic [11:0] cmd_pwm,
    input  logic [15:0] cmd_time,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    output logic        frame_done,
    output logic        err_id
);

    localparam logic [31:0] ID_SAT   = 32'(10**ID_DIGITS - 1);
    localparam logic [31:0] PWM_SAT  = 32'(10**PWM_DIGITS - 1);
    localparam logic [31:0] TIME_SAT = 32'(10**TIME_DIGITS - 1);
    localparam logic [31:0] PWM_LO   = 32'(PWM_MIN);
    localparam logic [31:0] PWM_HI   = 32'(PWM_MAX);
    localparam logic [31:0] N_SERVO  = 32'(NUM_SERVO);

    // Byte positions of the field separators within the frame
    localparam int P_POS    = 1 + ID_DIGITS;
    localparam int T_POS    = P_POS + 1 + PWM_DIGITS;
    localparam int X_POS    = T_POS + 1 + TIME_DIGITS;
    localparam int FLEN     = X_POS + 1 + ((APPEND_CRLF != 0) ? 2 : 0);
    localparam logic [4:0] LAST_IDX = 5'(FLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_SEND, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [4:0]  idx_q;
    logic [15:0] id_bin_q, pwm_bin_q, time_bin_q;
    logic [19:0] id_bcd_q, pwm_bcd_q, time_bcd_q;
    logic [7:0]  tx_data_q;
    logic        err_q;

    logic        accept, id_ok;
    logic [15:0] id_c, pwm_cl, pwm_c, time_c;
    logic [4:0]  nxt_idx;
    logic [7:0]  nxt_byte;

    function automatic logic [19:0] dd_step(input logic [19:0] b, input logic bit_in);
        logic [19:0] t;
        t = b;
        for (int k = 0; k < 5; k++) begin
            if (t[4*k +: 4] >= 4'd5) t[4*k +: 4] = t[4*k +: 4] + 4'd3;
        end
        return {t[18:0], bit_in};
    endfunction

    function automatic logic [7:0] digit(input logic [19:0] bcd, input int n);
        logic [19:0] s;
        s = bcd >> (4 * n);
        return {4'h3, s[3:0]};
    endfunction

    assign accept = cmd_valid && (state_q == S_IDLE);
    assign id_ok  = {24'd0, cmd_id} < N_SERVO;

    // Clamp PWM into the legal range first, then saturate every field to its digit count
    always_comb begin
        id_c = ({24'd0, cmd_id} > ID_SAT) ? ID_SAT[15:0] : {8'd0, cmd_id};
        if ({20'd0, cmd_pwm} < PWM_LO)      pwm_cl = PWM_LO[15:0];
        else if ({20'd0, cmd_pwm} > PWM_HI) pwm_cl = PWM_HI[15:0];
        else                                pwm_cl = {4'd0, cmd_pwm};
        pwm_c  = ({16'd0, pwm_cl} > PWM_SAT) ? PWM_SAT[15:0] : pwm_cl;
        time_c = ({16'd0, cmd_time} > TIME_SAT) ? TIME_SAT[15:0] : cmd_time;
    end

    assign nxt_idx = idx_q + 5'd1;

    always_comb begin
        int i;
        i        = int'(nxt_idx);
        nxt_byte = 8'h00;
        if (i < P_POS)           nxt_byte = digit(id_bcd_q, P_POS - 1 - i);
        else if (i == P_POS)     nxt_byte = 8'h50;
        else if (i < T_POS)      nxt_byte = digit(pwm_bcd_q, T_POS - 1 - i);
        else if (i == T_POS)     nxt_byte = 8'h54;
        else if (i < X_POS)      nxt_byte = digit(time_bcd_q, X_POS - 1 - i);
        else if (i == X_POS)     nxt_byte = 8'h21;
        else if (i == X_POS + 1) nxt_byte = 8'h0D;
        else                     nxt_byte = 8'h0A;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && id_ok) state_d = S_CONV;
            S_CONV: if (cnt_q == 4'd15) state_d = S_SEND;
            S_SEND: if (tx_data_ready && (idx_q == LAST_IDX)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= 5'd0;
            id_bin_q   <= 16'd0;
            pwm_bin_q  <= 16'd0;
            time_bin_q <= 16'd0;
            id_bcd_q   <= 20'd0;
            pwm_bcd_q  <= 20'd0;
            time_bcd_q <= 20'd0;
            tx_data_q  <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= accept && !id_ok;
            case (state_q)
                S_IDLE: begin
                    if (accept && id_ok) begin
                        id_bin_q   <= id_c;
                        pwm_bin_q  <= pwm_c;
                        time_bin_q <= time_c;
                        id_bcd_q   <= 20'd0;
                        pwm_bcd_q  <= 20'd0;
                        time_bcd_q <= 20'd0;
                        cnt_q      <= 4'd0;
                    end
                end
                S_CONV: begin
                    cnt_q      <= cnt_q + 4'd1;
                    id_bin_q   <= {id_bin_q[14:0], 1'b0};
                    pwm_bin_q  <= {pwm_bin_q[14:0], 1'b0};
                    time_bin_q <= {time_bin_q[14:0], 1'b0};
                    id_bcd_q   <= dd_step(id_bcd_q, id_bin_q[15]);
                    pwm_bcd_q  <= dd_step(pwm_bcd_q, pwm_bin_q[15]);
                    time_bcd_q <= dd_step(time_bcd_q, time_bin_q[15]);
                    if (cnt_q == 4'd15) begin
                        tx_data_q <= 8'h23;
                        idx_q     <= 5'd0;
                    end
                end
                S_SEND: begin
                    if (tx_data_ready) begin
                        if (idx_q == LAST_IDX) begin
                            tx_data_q <= 8'd0;
                        end else begin
                            idx_q     <= nxt_idx;
                            tx_data_q <= nxt_byte;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign tx_data_valid = (state_q == S_SEND);
    assign frame_done    = (state_q == S_DONE);
    assign err_id        = err_q;
    assign tx_data       = tx_data_q;

endmodule

// File: tb/tb_servo_cmd_framer.sv
// tb/tb_servo_cmd_framer.sv - self-checking bench for servo_cmd_framer
module tb_servo_cmd_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_id = 8'd0;
    logic [11:0] cmd_pwm = 12'd0;
    logic [15:0] cmd_time = 16'd0;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready = 1'b1;
    logic        frame_done;
    logic        err_id;

    logic        cmd_valid1 = 1'b0;
    logic        cmd_ready1;
    logic [7:0]  cmd_id1 = 8'd0;
    logic [11:0] cmd_pwm1 = 12'd0;
    logic [15:0] cmd_time1 = 16'd0;
    logic [7:0]  tx_data1;
    logic        tx_data_valid1;
    logic        tx_data_ready1 = 1'b1;
    logic        frame_done1;
    logic        err_id1;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbq[$];

    typedef struct {
        logic [7:0]  id;
        logic [11:0] pwm;
        logic [15:0] tim;
        string       exp;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    servo_cmd_framer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_id(cmd_id), .cmd_pwm(cmd_pwm), .cmd_time(cmd_time),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .frame_done(frame_done), .err_id(err_id)
    );

    servo_cmd_framer #(.APPEND_CRLF(1)) dut_crlf (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_id(cmd_id1), .cmd_pwm(cmd_pwm1), .cmd_time(cmd_time1),
        .tx_data(tx_data1), .tx_data_valid(tx_data_valid1), .tx_data_ready(tx_data_ready1),
        .frame_done(frame_done1), .err_id(err_id1)
    );

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every transferred byte must match the next expected one
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n) begin
            if (prev_stall) begin
                chk(tx_data_valid === 1'b1, "stall_valid_held", int'(tx_data_valid), 1);
                chk(tx_data === prev_data, "stall_data_held", int'(tx_data), int'(prev_data));
            end
            if (tx_data_valid && tx_data_ready) begin
                if (sbq.size() == 0) begin
                    chk(1'b0, "unexpected_byte", int'(tx_data), -1);
                end else begin
                    e = sbq.pop_front();
                    chk(tx_data === e, "frame_byte", int'(tx_data), int'(e));
                end
            end
            prev_stall = tx_data_valid && !tx_data_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) sbq.push_back(s[i]);
    endtask

    task automatic issue(input logic [7:0] id, input logic [11:0] pwm, input logic [15:0] tim);
        @(posedge clk);
        #1;
        chk(cmd_ready === 1'b1, "ready_in_idle", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_id    = id;
        cmd_pwm   = pwm;
        cmd_time  = tim;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v, input bit spam);
        int k, first, done;
        push_str(v.exp);
        issue(v.id, v.pwm, v.tim);
        if (spam) begin
            cmd_id   = 8'd2;
            cmd_pwm  = 12'd999;
            cmd_time = 16'd1;
        end else begin
            cmd_valid = 1'b0;
        end
        k = 0; first = 0; done = 0;
        while (k < 200 && done == 0) begin
            @(negedge clk);
            k++;
            if (spam && k == 20) cmd_valid = 1'b0;
            if (tx_data_valid && first == 0) first = k;
            if (frame_done) done = k;
        end
        cmd_valid = 1'b0;
        chk(first == 17, "first_byte_latency", first, 17);
        chk(done == 32, "frame_done_cycle", done, 32);
        chk(sbq.size() == 0, "bytes_outstanding", sbq.size(), 0);
        @(negedge clk);
        chk(frame_done === 1'b0, "frame_done_pulse", int'(frame_done), 0);
        chk(tx_data_valid === 1'b0, "valid_after_frame", int'(tx_data_valid), 0);
        chk(cmd_ready === 1'b1, "ready_after_frame", int'(cmd_ready), 1);
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (tx_data_valid) seen = 1'b1;
        end
        chk(seen, "valid_timeout", int'(seen), 1);
    endtask

    task automatic set_vec(input int i, input logic [7:0] id, input logic [11:0] pwm,
                           input logic [15:0] tim, input string s);
        vecs[i].id = id; vecs[i].pwm = pwm; vecs[i].tim = tim; vecs[i].exp = s;
    endtask

    initial begin
        bit seen;
        bit any_valid;
        int k;
        logic [7:0] got[$];
        logic [7:0] exp1[$];
        string s1;

        set_vec(0, 8'd1, 12'd600,  16'd2000,  "#001P0600T2000!");
        set_vec(1, 8'd2, 12'd100,  16'd5,     "#002P0500T0005!");
        set_vec(2, 8'd3, 12'd3000, 16'd65535, "#003P2500T9999!");
        set_vec(3, 8'd5, 12'd2500, 16'd9999,  "#005P2500T9999!");
        set_vec(4, 8'd0, 12'd500,  16'd0,     "#000P0500T0000!");
        set_vec(5, 8'd4, 12'd4095, 16'd10000, "#004P2500T9999!");
        set_vec(6, 8'd5, 12'd1234, 16'd777,   "#005P1234T0777!");

        repeat (3) @(negedge clk);
        chk(tx_data === 8'd0, "reset_tx_data", int'(tx_data), 0);
        chk(tx_data_valid === 1'b0, "reset_valid", int'(tx_data_valid), 0);
        chk(frame_done === 1'b0, "reset_frame_done", int'(frame_done), 0);
        chk(err_id === 1'b0, "reset_err_id", int'(err_id), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk(cmd_ready === 1'b1, "reset_ready", int'(cmd_ready), 1);

        for (int i = 0; i < 7; i++) run_frame(vecs[i], i == 0);

        // Out-of-range IDs are dropped with a single err_id pulse
        for (int j = 0; j < 2; j++) begin
            issue((j == 0) ? 8'd6 : 8'd255, 12'd1000, 16'd100);
            cmd_valid = 1'b0;
            @(negedge clk);
            chk(err_id === 1'b1, "err_id_pulse", int'(err_id), 1);
            @(negedge clk);
            chk(err_id === 1'b0, "err_id_single", int'(err_id), 0);
            any_valid = 1'b0;
            repeat (30) begin
                @(negedge clk);
                if (tx_data_valid) any_valid = 1'b1;
            end
            chk(any_valid == 1'b0, "err_no_frame", int'(any_valid), 0);
            run_frame(vecs[6 - j], 1'b0);
        end

        // Back-pressure: hold ready low for 100 cycles while byte index 6 is presented
        push_str(vecs[0].exp);
        issue(vecs[0].id, vecs[0].pwm, vecs[0].tim);
        cmd_valid = 1'b0;
        wait_valid(seen);
        repeat (6) @(posedge clk);
        #1;
        tx_data_ready = 1'b0;
        repeat (100) begin
            @(negedge clk);
            chk(tx_data === 8'h36, "stall_byte6", int'(tx_data), 8'h36);
        end
        @(posedge clk);
        #1;
        tx_data_ready = 1'b1;
        k = 0;
        while (k < 100 && !frame_done) begin
            @(negedge clk);
            k++;
        end
        chk(frame_done === 1'b1, "stall_frame_done", int'(frame_done), 1);
        chk(sbq.size() == 0, "stall_bytes_outstanding", sbq.size(), 0);

        // Reset in the middle of the frame discards the remaining bytes
        @(negedge clk);
        push_str(vecs[1].exp);
        issue(vecs[1].id, vecs[1].pwm, vecs[1].tim);
        cmd_valid = 1'b0;
        wait_valid(seen);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk(tx_data_valid === 1'b0, "reset_mid_valid", int'(tx_data_valid), 0);
        chk(tx_data === 8'd0, "reset_mid_data", int'(tx_data), 0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(cmd_ready === 1'b1, "reset_mid_ready", int'(cmd_ready), 1);
        any_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (tx_data_valid) any_valid = 1'b1;
        end
        chk(any_valid == 1'b0, "reset_no_stale", int'(any_valid), 0);
        run_frame(vecs[3], 1'b0);

        // CR/LF variant on the second instance
        s1 = "#000P0500T1000!";
        for (int i = 0; i < s1.len(); i++) exp1.push_back(s1[i]);
        exp1.push_back(8'h0D);
        exp1.push_back(8'h0A);
        @(posedge clk);
        #1;
        cmd_valid1 = 1'b1; cmd_id1 = 8'd0; cmd_pwm1 = 12'd500; cmd_time1 = 16'd1000;
        @(posedge clk);
        #1;
        cmd_valid1 = 1'b0;
        k = 0;
        while (k < 200 && !frame_done1) begin
            @(negedge clk);
            k++;
            if (tx_data_valid1 && tx_data_ready1) got.push_back(tx_data1);
        end
        chk(frame_done1 === 1'b1, "crlf_frame_done", int'(frame_done1), 1);
        chk(got.size() == 17, "crlf_length", got.size(), 17);
        for (int i = 0; i < 17; i++) begin
            if (i < got.size()) chk(got[i] === exp1[i], "crlf_byte", int'(got[i]), int'(exp1[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_cmd_framer.md
SERVO_CMD_FRAMER -- requirements
Module: servo_cmd_framer

Interface
REQ-001 Parameter NUM_SERVO, default 6: number of valid servo IDs (0..NUM_SERVO-1).
REQ-002 Parameter ID_DIGITS, default 3: decimal digits for the ID field (legal 1..3).
REQ-003 Parameter PWM_DIGITS, default 4: decimal digits for the PWM field (legal 1..4).
REQ-004 Parameter TIME_DIGITS, default 4: decimal digits for the time field (legal 1..5).
REQ-005 Parameter PWM_MIN, default 500: lower PWM clamp.
REQ-006 Parameter PWM_MAX, default 2500: upper PWM clamp.
REQ-007 Parameter APPEND_CRLF, default 0: 1 appends 0x0D 0x0A after '!'.
REQ-008 Ports: one clock; reset is asynchronous and active-low.
REQ-009 clk  input  1  system clock, all logic on its rising edge.
REQ-010 rst_n  input  1  asynchronous active-low reset.
REQ-011 cmd_valid  input  1  command present.
REQ-012 cmd_ready  output  1  block can accept a command.
REQ-013 cmd_id  input  8  servo ID, unsigned binary.
REQ-014 cmd_pwm  input  12  pulse width in us, unsigned binary.
REQ-015 cmd_time  input  16  move time in ms, unsigned binary.
REQ-016 tx_data  output  8  ASCII byte to the UART transmitter.
REQ-017 tx_data_valid  output  1  tx_data holds a valid byte.
REQ-018 tx_data_ready  input  1  UART transmitter accepts the byte.
REQ-019 frame_done  output  1  one-cycle pulse after the last byte of a frame transfers.
REQ-020 err_id  output  1  one-cycle pulse when a command with an out-of-range ID is dropped.

Function
REQ-021 States: IDLE, CONV, SEND, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-022 Accept: cmd_valid&&cmd_ready at edge T latches id/pwm/time; if cmd_id>=NUM_SERVO, err_id=1 at T+1, no frame, state stays IDLE.
REQ-023 PWM clamped before conversion: <PWM_MIN -> PWM_MIN, >PWM_MAX -> PWM_MAX.
REQ-024 A field value >10^N-1 for its digit count N SHALL saturate to N nines (applies to id, clamped pwm, time).
REQ-025 CONV: sequential double-dabble on all three fields in parallel, exactly 16 cycles (T+1..T+16), then SEND.
REQ-026 Frame = '#', ID digits, 'P', PWM digits, 'T', time digits, '!', [0x0D 0x0A]; MSD first, leading zeros kept; default length 15 bytes.
REQ-027 First byte '#' with tx_data_valid=1 SHALL appear at T+17.
REQ-028 A byte transfers on tx_data_valid&&tx_data_ready; the next byte is presented the following cycle with valid held high (back-to-back, one byte per cycle max).
REQ-029 While valid=1 and ready=0, tx_data and tx_data_valid SHALL hold unchanged.
REQ-030 After the last byte transfers, tx_data_valid=0 next cycle, state DONE for one cycle with frame_done=1, then IDLE.
REQ-031 cmd_valid during CONV/SEND/DONE SHALL be ignored (not latched, not lost-acknowledged).
REQ-032 tx_data_valid SHALL never be 1 outside SEND.

Reset
REQ-033 rst_n=0 SHALL immediately force: state IDLE, tx_data=0, tx_data_valid=0, frame_done=0, err_id=0, byte counter 0, latched fields 0; cmd_ready=1 from first edge after release.
REQ-034 Reset mid-frame aborts the frame; no remaining bytes SHALL be emitted after release.

Verification
REQ-035 id=1,pwm=600,time=2000, ready=1 -> bytes "#001P0600T2000!" on 15 consecutive cycles from T+17, frame_done one cycle after '!'.
REQ-036 pwm=100 then pwm=3000 -> fields "P0500" and "P2500"; time=65535 with TIME_DIGITS=4 -> "T9999".
REQ-037 cmd_id=NUM_SERVO -> err_id one-cycle pulse at T+1, tx_data_valid stays 0, next command accepted normally.
REQ-038 tx_data_ready low for 100 cycles on byte 6 -> tx_data='6' stable throughout, no byte skipped or repeated.
REQ-039 rst_n asserted during byte 8 -> tx_data_valid=0 same cycle, after release cmd_ready=1 and no stale bytes.
REQ-040 APPEND_CRLF=1, id=0,pwm=500,time=1000 -> 17 bytes "#000P0500T1000!" then 0x0D 0x0A.
